// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder
//   SPI mode-0 responder emulating the far-end joystick module. Serves a
//   5-byte frame {X lo, X hi, Y lo, Y hi, buttons} MSB first and captures
//   the LED command carried in the first MOSI byte.
//
// Ports
//   CLK, RST_N          system clock (>= 8x SCK), async active-low reset
//   CS_n, SCK, MOSI     asynchronous SPI inputs from the initiator
//   MISO, MISO_OE       SPI data out; MISO_OE high while selected
//   x_pos, y_pos        10-bit positions to serve
//   buttons             3 button bits to serve
//   pos_valid           x_pos/y_pos/buttons are live when high
//   leds                LED command from the last complete frame
//   frame_done          1-cycle pulse at the end of a complete frame
//   frame_err           1-cycle pulse on an aborted or overlong frame
//   frame_count, err_count  (only with JSTK_FRAME_COUNT_EN defined)
//
// Build option
//   JSTK_FRAME_COUNT_EN adds frame_count[15:0] (wrapping count of
//   frame_done) and err_count[7:0] (saturating count of frame_err).

module jstk_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BYTES = 5,
    parameter int unsigned DEFAULT_POS = 512
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CS_n,
    input  logic        SCK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic [2:0]  buttons,
    input  logic        pos_valid,
    output logic [1:0]  leds,
    output logic        frame_done,
    output logic        frame_err
`ifdef JSTK_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
`endif
);

    localparam int unsigned BCW = $clog2(FRAME_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_OVER
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   cs_prev_q;
    logic                   sck_prev_q;

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;

    // CS_n chain resets to 0 ("selected") so that a CS_n already low at
    // reset release produces no falling edge; a fresh rise then fall is
    // needed before a frame can start. A CS_n high at release only yields
    // a rise, which is ignored in IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_n};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [6:0]       rx_shift_q, rx_shift_d;
    logic             cmd_set_q, cmd_set_d;
    logic [1:0]       cmd_leds_q, cmd_leds_d;
    logic [9:0]       snap_x_q, snap_x_d;
    logic [9:0]       snap_y_q, snap_y_d;
    logic [2:0]       snap_btn_q, snap_btn_d;
    logic [1:0]       leds_q, leds_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef JSTK_FRAME_COUNT_EN
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
`endif

    // Byte served at frame position idx; positions past the frame are 0.
    function automatic logic [7:0] tx_byte(input int unsigned idx,
                                           input logic [9:0]  x,
                                           input logic [9:0]  y,
                                           input logic [2:0]  b);
        logic [7:0] r;
        case (idx)
            0:       r = x[7:0];
            1:       r = {6'b0, x[9:8]};
            2:       r = y[7:0];
            3:       r = {6'b0, y[9:8]};
            4:       r = {5'b0, b};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            cmd_set_q  <= 1'b0;
            cmd_leds_q <= '0;
            snap_x_q   <= 10'(DEFAULT_POS);
            snap_y_q   <= 10'(DEFAULT_POS);
            snap_btn_q <= '0;
            leds_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef JSTK_FRAME_COUNT_EN
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
`endif
        end else begin
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            cmd_set_q  <= cmd_set_d;
            cmd_leds_q <= cmd_leds_d;
            snap_x_q   <= snap_x_d;
            snap_y_q   <= snap_y_d;
            snap_btn_q <= snap_btn_d;
            leds_q     <= leds_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef JSTK_FRAME_COUNT_EN
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        cmd_set_d  = cmd_set_q;
        cmd_leds_d = cmd_leds_q;
        snap_x_d   = snap_x_q;
        snap_y_d   = snap_y_q;
        snap_btn_d = snap_btn_q;
        leds_d     = leds_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        // Snapshot tracks the inputs only while idle, so a frame is coherent.
        if (state_q == ST_IDLE && pos_valid) begin
            snap_x_d   = x_pos;
            snap_y_d   = y_pos;
            snap_btn_d = buttons;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                    cmd_set_d  = 1'b0;
                    // B0 built from the value being latched this cycle so
                    // that B0 and later bytes come from the same snapshot.
                    tx_shift_d = tx_byte(0, snap_x_d, snap_y_d, snap_btn_d);
                end
            end

            ST_ACTIVE, ST_OVER: begin
                if (cs_rise) begin
                    // CS_n rise takes priority over any coincident SCK edge.
                    state_d = ST_IDLE;
                    if (state_q == ST_ACTIVE &&
                        byte_cnt_q == BCW'(FRAME_BYTES) && bit_cnt_q == 3'd0) begin
                        done_d = 1'b1;
                        if (cmd_set_q) begin
                            leds_d = cmd_leds_q;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (state_q == ST_ACTIVE) begin
                    if (sck_rise) begin
                        if (byte_cnt_q == BCW'(FRAME_BYTES)) begin
                            state_d = ST_OVER;
                        end else begin
                            rx_shift_d = {rx_shift_q[5:0], mosi_s};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_cnt_d = byte_cnt_q + BCW'(1);
                                if (byte_cnt_q == '0) begin
                                    // Only bit 7 and bits [1:0] of the command matter.
                                    cmd_set_d  = rx_shift_q[6];
                                    cmd_leds_d = {rx_shift_q[0], mosi_s};
                                end
                            end
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt_q == 3'd0 && byte_cnt_q != '0) begin
                            tx_shift_d = tx_byte(32'(byte_cnt_q), snap_x_q,
                                                 snap_y_q, snap_btn_q);
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

`ifdef JSTK_FRAME_COUNT_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (done_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign err_count   = err_cnt_q;
`endif

    // Output logic
    always_comb begin
        MISO    = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b0;
        MISO_OE = (state_q != ST_IDLE);
    end

    assign leds       = leds_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder
//   Scoreboard bench for jstk_spi_responder. Stimulus drives SPI frames and
//   pushes the expected frame outcome (pulse kind, LEDs, MISO bytes) into a
//   queue; a monitor pops and compares on each frame_done/frame_err pulse.

module tb_jstk_spi_responder;

    localparam int unsigned DEF  = 512;
    localparam int          HALF = 80;   // SCK half period: 8 CLK cycles

    logic        CLK;
    logic        RST_N, CS_n, SCK, MOSI;
    logic        MISO, MISO_OE;
    logic [9:0]  x_pos, y_pos;
    logic [2:0]  buttons;
    logic        pos_valid;
    logic [1:0]  leds;
    logic        frame_done, frame_err;
`ifdef JSTK_FRAME_COUNT_EN
    logic [15:0] frame_count;
    logic [7:0]  err_count;
`endif

    jstk_spi_responder #(
        .SYNC_STAGES(2),
        .FRAME_BYTES(5),
        .DEFAULT_POS(DEF)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .CS_n(CS_n), .SCK(SCK), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE),
        .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .pos_valid(pos_valid),
        .leds(leds), .frame_done(frame_done), .frame_err(frame_err)
`ifdef JSTK_FRAME_COUNT_EN
        , .frame_count(frame_count), .err_count(err_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        is_done;
        logic [1:0]  leds;
        logic [3:0]  nfull;
        logic [15:0] fc;
        logic [7:0]  ec;
        logic [63:0] bytes;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [9:0]  m_x, m_y;
    logic [2:0]  m_btn;
    logic [1:0]  m_leds;
    logic [15:0] m_fc;
    logic [7:0]  m_ec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // The frame is X and Y as little-endian 16-bit words, then the buttons.
    function automatic logic [7:0] ref_byte(input int i);
        logic [15:0] xw, yw;
        xw = {6'b0, m_x};
        yw = {6'b0, m_y};
        case (i)
            0: return xw[7:0];
            1: return xw[15:8];
            2: return yw[7:0];
            3: return yw[15:8];
            4: return {5'b0, m_btn};
            default: return 8'h00;
        endcase
    endfunction

    task automatic refresh_model();
        if (pos_valid) begin
            m_x   = x_pos;
            m_y   = y_pos;
            m_btn = buttons;
        end
    endtask

    // ---------------- MISO capture (initiator view) ----------------
    logic [7:0] cap_bytes [0:7];
    logic [7:0] cap_sr;
    int         cap_nbits;

    initial begin
        cap_nbits = 0;
        cap_sr    = '0;
        forever begin
            @(negedge CS_n);
            cap_nbits = 0;
        end
    end

    initial begin
        forever begin
            @(posedge SCK);
            if (CS_n === 1'b0) begin
                cap_sr = {cap_sr[6:0], MISO};
                cap_nbits++;
                if ((cap_nbits % 8) == 0 && cap_nbits <= 64)
                    cap_bytes[cap_nbits/8 - 1] = cap_sr;
            end
        end
    end

    // ---------------- Monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1 && (frame_done === 1'b1 || frame_err === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: done=%b err=%b, expected no pulse",
                             frame_done, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_done", 32'(frame_done), 32'(e.is_done));
                    check("frame_err", 32'(frame_err), 32'(!e.is_done));
                    check("leds", 32'(leds), 32'(e.leds));
                    check("miso_oe_after_frame", 32'(MISO_OE), 32'(0));
                    for (int i = 0; i < int'(e.nfull); i++)
                        check($sformatf("miso_byte%0d", i), 32'(cap_bytes[i]),
                              32'(e.bytes[8*i +: 8]));
`ifdef JSTK_FRAME_COUNT_EN
                    check("frame_count", 32'(frame_count), 32'(e.fc));
                    check("err_count", 32'(err_count), 32'(e.ec));
`endif
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic sck_bit(input logic v);
        MOSI = v;
        #(HALF);
        SCK = 1'b1;
        #(HALF);
        SCK = 1'b0;
    endtask

    task automatic do_frame(input int nbytes, input int extra, input logic [7:0] cmd,
                            input int chg_byte, input logic [9:0] chg_x);
        exp_t       e;
        logic [7:0] b;
        refresh_model();
        e = '0;
        for (int i = 0; i < 8; i++) e.bytes[8*i +: 8] = ref_byte(i);
        e.nfull   = 4'(nbytes > 8 ? 8 : nbytes);
        e.is_done = (nbytes == 5 && extra == 0);
        if (e.is_done) begin
            m_fc++;
            if (cmd[7]) m_leds = cmd[1:0];
        end else if (m_ec != 8'hFF) begin
            m_ec++;
        end
        e.leds = m_leds;
        e.fc   = m_fc;
        e.ec   = m_ec;
        exp_q.push_back(e);

        @(negedge CLK);
        CS_n = 1'b0;
        #(HALF);
        for (int i = 0; i < nbytes; i++) begin
            if (i == chg_byte) x_pos = chg_x;
            b = (i == 0) ? cmd : 8'($urandom);
            for (int k = 7; k >= 0; k--) sck_bit(b[k]);
        end
        for (int k = 0; k < extra; k++) sck_bit(1'($urandom));
        #(HALF);
        CS_n = 1'b1;
        repeat (20) @(negedge CLK);
        refresh_model();
    endtask

    initial begin
        int nb, ex, r;
        RST_N = 1'b0; CS_n = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        x_pos = '0; y_pos = '0; buttons = '0; pos_valid = 1'b0;
        m_x = 10'(DEF); m_y = 10'(DEF); m_btn = '0; m_leds = '0; m_fc = '0; m_ec = '0;

        repeat (3) @(negedge CLK);
        check("rst_miso", 32'(MISO), 32'(0));
        check("rst_miso_oe", 32'(MISO_OE), 32'(0));
        check("rst_leds", 32'(leds), 32'(0));
        check("rst_done", 32'(frame_done), 32'(0));
        check("rst_err", 32'(frame_err), 32'(0));
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);

        // Default positions, all-zero MOSI
        do_frame(5, 0, 8'h00, -1, 10'h0);

        // Live positions, LED command 10
        x_pos = 10'h21C; y_pos = 10'h3A5; buttons = 3'b101; pos_valid = 1'b1;
        repeat (2) @(negedge CLK);
        do_frame(5, 0, 8'h82, -1, 10'h0);

        // x_pos changes mid-frame; cmd[7]=0 keeps LEDs
        do_frame(5, 0, 8'h05, 2, 10'h0FF);
        do_frame(5, 0, 8'h00, -1, 10'h0);

        // Abort after 3 bytes + 4 bits
        do_frame(3, 4, 8'h81, -1, 10'h0);

        // Overlong 6-byte frame
        do_frame(6, 0, 8'h83, -1, 10'h0);

        // Reset during byte 2 with CS_n held low
        refresh_model();
        @(negedge CLK);
        CS_n = 1'b0;
        #(HALF);
        for (int k = 7; k >= 0; k--) sck_bit(k == 7 || k == 0);
        for (int k = 0; k < 3; k++) sck_bit(1'b1);
        #(HALF/2);
        RST_N = 1'b0;
        #1;
        check("midrst_miso", 32'(MISO), 32'(0));
        check("midrst_miso_oe", 32'(MISO_OE), 32'(0));
        check("midrst_leds", 32'(leds), 32'(0));
        check("midrst_done", 32'(frame_done), 32'(0));
        check("midrst_err", 32'(frame_err), 32'(0));
        m_leds = '0; m_fc = '0; m_ec = '0;
        m_x = 10'(DEF); m_y = 10'(DEF); m_btn = '0;
        #29;
        RST_N = 1'b1;
        refresh_model();
        for (int k = 0; k < 8; k++) begin
            sck_bit(1'b1);
            check("postrst_miso_oe", 32'(MISO_OE), 32'(0));
        end
        #(HALF);
        CS_n = 1'b1;
        repeat (20) @(negedge CLK);
        do_frame(5, 0, 8'h83, -1, 10'h0);

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            x_pos     = 10'($urandom);
            y_pos     = 10'($urandom);
            buttons   = 3'($urandom);
            pos_valid = 1'($urandom_range(0, 1));
            @(negedge CLK);
            r = int'($urandom_range(0, 3));
            if (r < 2) begin
                nb = 5; ex = 0;
            end else begin
                nb = int'($urandom_range(1, 6));
                ex = int'($urandom_range(0, 7));
            end
            do_frame(nb, ex, 8'($urandom), -1, 10'h0);
        end

        // Bounded wait for the last outcome to be observed
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
